// File: rtl/roe_sequencer_if.sv
// Bus bundle between the R.O.E sequencer and its neighbours (decoder, ALU flag,
// instruction ROM address and data-memory handshake).
interface roe_sequencer_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned OFF_W = 6,
    parameter int unsigned CNT_W = 16
) ();

    // Decoder / ALU / memory inputs to the sequencer
    logic             start;
    logic             halt;
    logic             mem_access;
    logic             branch_req;
    logic             branch_cond;
    logic [OFF_W-1:0] branch_offset;
    logic             mem_ready;

    // Sequencer outputs
    logic [PC_W-1:0]  pc;
    logic             ir_load;
    logic             reg_commit;
    logic             mem_req;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] instr_count;

    // Sequencer side: owns the PC and the memory request
    modport master (
        input  start, halt, mem_access, branch_req, branch_cond, branch_offset, mem_ready,
        output pc, ir_load, reg_commit, mem_req, done, timeout_err, instr_count
    );

    // Environment side: decoder, ALU, ROM and data memory
    modport slave (
        output start, halt, mem_access, branch_req, branch_cond, branch_offset, mem_ready,
        input  pc, ir_load, reg_commit, mem_req, done, timeout_err, instr_count
    );

endinterface

// File: rtl/roe_sequencer.sv
// R.O.E instruction sequencer: steps each instruction through FETCH, EXEC and an
// optional MEM_WAIT, owns the PC, and issues exactly one reg_commit per retired
// instruction. Halt and memory timeout both park the machine in DONE.
module roe_sequencer #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned OFF_W       = 6,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input logic             i_clk,
    input logic             i_reset,
    roe_sequencer_if.master bus
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMemWait,
        StDone
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_ir_load;
    logic              r_mem_req;
    logic              r_done;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_instr_count;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic [PC_W-1:0]   w_off_ext;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_branch_taken;
    logic              w_exec_normal;
    logic              w_mem_done;
    logic              w_mem_last;

    // PC arithmetic and commit decode; additions wrap naturally at PC_W bits
    always_comb begin
        w_off_ext      = PC_W'($signed(bus.branch_offset));
        w_pc_inc       = r_pc + PC_W'(1);
        w_branch_taken = bus.branch_req & bus.branch_cond;
        w_pc_next      = w_branch_taken ? (r_pc + w_off_ext) : w_pc_inc;
        w_cnt_inc      = (r_instr_count == '1) ? r_instr_count : r_instr_count + CNT_W'(1);
        w_exec_normal  = (r_state == StExec) & ~bus.halt & ~bus.mem_access;
        w_mem_done     = (r_state == StMemWait) & bus.mem_ready;
        w_mem_last     = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    end

    // Sequencer FSM; ir_load/mem_req/done are registered on entry to their state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_pc          <= '0;
            r_ir_load     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_instr_count <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_ir_load <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state       <= StFetch;
                        r_pc          <= '0;
                        r_instr_count <= '0;
                        r_ir_load     <= 1'b1;
                    end
                end
                StFetch: begin
                    r_state <= StExec;
                end
                StExec: begin
                    if (bus.halt) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else if (bus.mem_access) begin
                        r_state    <= StMemWait;
                        r_mem_req  <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state       <= StFetch;
                        r_ir_load     <= 1'b1;
                        r_pc          <= w_pc_next;
                        r_instr_count <= w_cnt_inc;
                    end
                end
                StMemWait: begin
                    if (bus.mem_ready) begin
                        r_state       <= StFetch;
                        r_ir_load     <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_pc          <= w_pc_inc;
                        r_instr_count <= w_cnt_inc;
                    end else if (w_mem_last) begin
                        // This is the MEM_TIMEOUT-th cycle without ready: abandon
                        r_state       <= StDone;
                        r_mem_req     <= 1'b0;
                        r_done        <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                StDone: begin
                    if (bus.start) begin
                        r_state       <= StFetch;
                        r_pc          <= '0;
                        r_instr_count <= '0;
                        r_done        <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_ir_load     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.ir_load     = r_ir_load;
    // Commit depends on this cycle's decoder flags / mem_ready, so it cannot be registered
    assign bus.reg_commit  = w_exec_normal | w_mem_done;
    assign bus.mem_req     = r_mem_req;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_roe_sequencer.sv
// Directed bench for roe_sequencer. A second instance with CNT_W=4 runs in
// lockstep on the same inputs to exercise instruction-count saturation.
module tb_roe_sequencer;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    roe_sequencer_if #(.PC_W(10), .OFF_W(6), .CNT_W(16)) bus ();
    roe_sequencer_if #(.PC_W(10), .OFF_W(6), .CNT_W(4))  bus4 ();

    roe_sequencer #(.PC_W(10), .OFF_W(6), .MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    roe_sequencer #(.PC_W(10), .OFF_W(6), .MEM_TIMEOUT(16), .CNT_W(4)) u_dut4 (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus4)
    );

    assign bus4.start         = bus.start;
    assign bus4.halt          = bus.halt;
    assign bus4.mem_access    = bus.mem_access;
    assign bus4.branch_req    = bus.branch_req;
    assign bus4.branch_cond   = bus.branch_cond;
    assign bus4.branch_offset = bus.branch_offset;
    assign bus4.mem_ready     = bus.mem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // In FETCH: ROM address and ir_load, no commit
    task automatic fetch_check(input logic [9:0] pc_exp);
        check("fetch_irload", bus.ir_load, 1);
        check("fetch_pc", bus.pc, pc_exp);
        check("fetch_nocommit", bus.reg_commit, 0);
        step();
    endtask

    // In EXEC: non-memory instruction, optionally a branch
    task automatic exec_alu(input logic br, input logic cond, input logic [5:0] off);
        bus.branch_req    = br;
        bus.branch_cond   = cond;
        bus.branch_offset = off;
        #1;
        check("exec_commit", bus.reg_commit, 1);
        check("exec_irload_low", bus.ir_load, 0);
        step();
        bus.branch_req    = 1'b0;
        bus.branch_cond   = 1'b0;
        bus.branch_offset = '0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.halt = 1'b0;
        bus.mem_access = 1'b0;
        bus.branch_req = 1'b0;
        bus.branch_cond = 1'b0;
        bus.branch_offset = '0;
        bus.mem_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_pc", bus.pc, 0);
        check("rst_irload", bus.ir_load, 0);
        check("rst_commit", bus.reg_commit, 0);
        check("rst_memreq", bus.mem_req, 0);
        check("rst_done", bus.done, 0);
        check("rst_timeout", bus.timeout_err, 0);
        check("rst_count", bus.instr_count, 0);
        reset = 1'b0;
        step();
        check("idle_hold_irload", bus.ir_load, 0);

        // Four ALU instructions then halt at pc 4
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            fetch_check(10'(i));
            exec_alu(1'b0, 1'b0, 6'h00);
        end
        fetch_check(10'd4);
        bus.halt = 1'b1;
        #1;
        check("halt_nocommit", bus.reg_commit, 0);
        step();
        bus.halt = 1'b0;
        check("halt_done", bus.done, 1);
        check("halt_pc", bus.pc, 4);
        check("halt_count", bus.instr_count, 4);
        step();
        check("done_held", bus.done, 1);
        check("done_nocommit", bus.reg_commit, 0);

        // Restart; branches: taken -3 at pc 5, not-taken at pc 5, then wraps
        pulse_start();
        check("restart_done_clr", bus.done, 0);
        check("restart_count", bus.instr_count, 0);
        for (int i = 0; i < 5; i++) begin
            fetch_check(10'(i));
            exec_alu(1'b0, 1'b0, 6'h00);
        end
        fetch_check(10'd5);
        exec_alu(1'b1, 1'b1, 6'h3D);
        for (int i = 2; i < 5; i++) begin
            fetch_check(10'(i));
            exec_alu(1'b0, 1'b0, 6'h00);
        end
        fetch_check(10'd5);
        exec_alu(1'b1, 1'b0, 6'h3D);
        fetch_check(10'd6);
        exec_alu(1'b1, 1'b1, 6'h39);    // 6 - 7 -> 1023
        fetch_check(10'd1023);
        exec_alu(1'b1, 1'b1, 6'h02);    // 1023 + 2 -> 1
        fetch_check(10'd1);
        exec_alu(1'b1, 1'b1, 6'h3E);    // 1 - 2 -> 1023
        fetch_check(10'd1023);
        exec_alu(1'b0, 1'b0, 6'h00);    // 1023 + 1 -> 0

        // LW at pc 0, mem_ready on the third wait cycle
        fetch_check(10'd0);
        bus.mem_access = 1'b1;
        #1;
        check("lw_exec_nocommit", bus.reg_commit, 0);
        step();
        bus.mem_access = 1'b0;
        check("lw_wait1_req", bus.mem_req, 1);
        check("lw_wait1_nocommit", bus.reg_commit, 0);
        step();
        check("lw_wait2_req", bus.mem_req, 1);
        check("lw_wait2_pc", bus.pc, 0);
        step();
        bus.mem_ready = 1'b1;
        #1;
        check("lw_wait3_req", bus.mem_req, 1);
        check("lw_ready_commit", bus.reg_commit, 1);
        step();
        check("lw_req_drop", bus.mem_req, 0);
        check("lw_count", bus.instr_count, 15);
        // mem_ready outside MEM_WAIT must not commit
        check("stray_ready_nocommit", bus.reg_commit, 0);
        bus.mem_ready = 1'b0;
        fetch_check(10'd1);

        // SW at pc 1 that never completes
        bus.mem_access = 1'b1;
        #1;
        check("sw_exec_nocommit", bus.reg_commit, 0);
        step();
        bus.mem_access = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("sw_wait_req", bus.mem_req, 1);
            check("sw_wait_nocommit", bus.reg_commit, 0);
            check("sw_wait_done_low", bus.done, 0);
            step();
        end
        check("to_err", bus.timeout_err, 1);
        check("to_done", bus.done, 1);
        check("to_req_drop", bus.mem_req, 0);
        check("to_count", bus.instr_count, 15);
        check("to_nocommit", bus.reg_commit, 0);
        pulse_start();
        check("to_restart_err_clr", bus.timeout_err, 0);
        check("to_restart_pc", bus.pc, 0);
        check("to_restart_done_clr", bus.done, 0);

        // Start during EXEC ignored, reset during MEM_WAIT
        fetch_check(10'd0);
        exec_alu(1'b0, 1'b0, 6'h00);
        fetch_check(10'd1);
        bus.mem_access = 1'b1;
        bus.start = 1'b1;
        step();
        bus.mem_access = 1'b0;
        bus.start = 1'b0;
        check("exec_start_ignored_req", bus.mem_req, 1);
        check("exec_start_ignored_pc", bus.pc, 1);
        check("exec_start_ignored_irload", bus.ir_load, 0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_req", bus.mem_req, 0);
        check("midrst_pc", bus.pc, 0);
        check("midrst_count", bus.instr_count, 0);
        check("midrst_done", bus.done, 0);
        step();
        check("midrst_idle_irload", bus.ir_load, 0);

        // Twenty instructions: 16-bit counter reads 20, 4-bit one saturates at 15
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            fetch_check(10'(i));
            exec_alu(1'b0, 1'b0, 6'h00);
        end
        fetch_check(10'd20);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("sat_count16", bus.instr_count, 20);
        check("sat_count4", bus4.instr_count, 15);
        check("sat_done4", bus4.done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/roe_sequencer.md
Name: roe_sequencer

Overview:
- Multi-cycle instruction sequencer for the R.O.E core.
- Owns the program counter and steps each 9-bit instruction through fetch, execute and optional data-memory wait.
- Gates the decoder's architectural side effects (register write, pointer redefine) with a single commit strobe, and handles branch redirect, halt, and a data-memory handshake with timeout.
- Sits between instruction ROM, instruction decoder, ALU branch flag and data memory.

Parameters:
PC_W, 10, program counter width; PC wraps modulo 2^PC_W
OFF_W, 6, signed branch offset width
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before error (>=1)
CNT_W, 16, width of committed-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  level/pulse; begins execution from PC 0 when IDLE or DONE
halt  in  1  decoder flag: current instruction is halt
mem_access  in  1  decoder mem_read OR mem_write for current instruction
branch_req  in  1  decoder flag: current instruction is BNZ
branch_cond  in  1  ALU branch-taken result (valid in EXEC)
branch_offset  in  OFF_W  signed two's-complement PC offset
mem_ready  in  1  data memory completion strobe
pc  out  PC_W  instruction ROM address
ir_load  out  1  load instruction register from ROM data
reg_commit  out  1  one-cycle enable ANDed with reg_write / set_read* / set_write
mem_req  out  1  data memory request, held until accepted
done  out  1  program finished (halt or timeout)
timeout_err  out  1  sticky: memory timeout occurred
instr_count  out  CNT_W  committed instructions since last start, saturating

Behaviour:
- Reset (synchronous, active-high, sampled every edge, overrides everything incl. mid-MEM_WAIT): state=IDLE, pc=0, ir_load=0, reg_commit=0, mem_req=0, done=0, timeout_err=0, instr_count=0, wait counter=0.
- States: IDLE, FETCH, EXEC, MEM_WAIT, DONE. State register-based; outputs decoded from state plus inputs as listed.
- IDLE:
  - start=1 -> FETCH, pc=0, instr_count=0.
  - Otherwise hold.
- FETCH:
  - ir_load=1 for exactly this cycle; ROM has 1-cycle read latency.
  - Always -> EXEC next cycle.
- EXEC: decoder inputs valid. Priority halt > mem_access > normal.
  - halt=1 -> DONE; no commit; pc unchanged.
  - mem_access=1 -> MEM_WAIT; mem_req=1 from next cycle; no commit this cycle; wait counter=0.
  - Otherwise reg_commit=1, instr_count+1 (saturate at 2^CNT_W-1), -> FETCH.
  - Next pc: if branch_req & branch_cond, pc + sign_extend(branch_offset) (modulo 2^PC_W, wrap both directions); else pc+1 (wraps 2^PC_W-1 -> 0).
- MEM_WAIT:
  - mem_req=1 every cycle in this state.
  - mem_ready=1 -> reg_commit=1 this cycle, pc+1, instr_count+1, mem_req deasserts next cycle, -> FETCH.
  - Else wait counter+1; when counter reaches MEM_TIMEOUT without ready: timeout_err=1 (sticky), no commit, -> DONE.
  - mem_ready sampled in any state other than MEM_WAIT is ignored.
- DONE:
  - done=1 held.
  - start=1 -> FETCH, pc=0, instr_count=0, done=0; timeout_err clears on this restart.
- start while in FETCH/EXEC/MEM_WAIT: ignored.
- Latency: non-memory instruction = 2 cycles (FETCH+EXEC). Memory instruction = 3 + N cycles, where N = cycles before mem_ready.
- Commit semantics:
  - reg_commit is never asserted for halt or timed-out instructions.
  - Exactly one reg_commit pulse per completed instruction.

Test Plan:
- Reset, start=1 one cycle, four ALU instrs (no mem, no branch), then halt -> pc 0,1,2,3,4; reg_commit pulses every 2nd cycle; done=1 at pc=4; instr_count=4.
- BNZ at pc=5, branch_cond=1, offset=-3 -> next fetch pc=2. Repeat with branch_cond=0 -> pc=6. offset=+2 at pc=1023 -> pc=1 (wrap).
- LW at pc=0, mem_ready after 3 wait cycles -> mem_req high exactly 3 cycles (ready on 3rd), single reg_commit coincident with mem_ready, then FETCH pc=1.
- SW with mem_ready never asserted, MEM_TIMEOUT=16 -> after 16 MEM_WAIT cycles timeout_err=1, done=1, no commit; start -> timeout_err=0, pc=0.
- reset asserted during MEM_WAIT -> next cycle IDLE, mem_req=0, pc=0, instr_count=0; start pulse during EXEC ignored.
- Preload instr_count near max (CNT_W=4, 20 instrs) -> saturates at 15.
